ahbl_decoder_n: RTL and testbench

Parametrised AHB-Lite address decoder/splitter that fans one master-side AHB-Lite port out to `N_PORTS` slave ports selected by a per-port address/mask map. It sits between the CPU bus and the peripheral/SRAM/bridge slaves in an AHBL layer. It adds a built-in default slave that returns a two-cycle ERROR response for unmapped transfers. It also tracks the data phase in a registered state machine, so slaves without their own `hresp` logic can sit behind it safely.

---
 rtl/ahbl_decoder_n.sv | 189 ++++++++++++++++++
 tb/tb_ahbl_decoder_n.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_decoder_n.sv
// AHB-Lite address decoder/splitter with built-in default (ERROR) slave.
// Optional unmapped-access capture: AHBL_DECODER_ERRCAPTURE_EN.
module ahbl_decoder_n #(
   parameter int N_PORTS = 4,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
   parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        src_hready,
   output logic                        src_hready_resp,
   output logic                        src_hresp,
   input  logic [W_ADDR-1:0]           src_haddr,
   input  logic                        src_hwrite,
   input  logic [1:0]                  src_htrans,
   input  logic [2:0]                  src_hsize,
   input  logic [2:0]                  src_hburst,
   input  logic [3:0]                  src_hprot,
   input  logic                        src_hmastlock,
   input  logic [W_DATA-1:0]           src_hwdata,
   output logic [W_DATA-1:0]           src_hrdata,
   output logic [N_PORTS-1:0]          dst_hready,
   input  logic [N_PORTS-1:0]          dst_hready_resp,
   input  logic [N_PORTS-1:0]          dst_hresp,
   output logic [N_PORTS*W_ADDR-1:0]   dst_haddr,
   output logic [N_PORTS-1:0]          dst_hwrite,
   output logic [N_PORTS*2-1:0]        dst_htrans,
   output logic [N_PORTS*3-1:0]        dst_hsize,
   output logic [N_PORTS*3-1:0]        dst_hburst,
   output logic [N_PORTS*4-1:0]        dst_hprot,
   output logic [N_PORTS-1:0]          dst_hmastlock,
   output logic [N_PORTS*W_DATA-1:0]   dst_hwdata,
   input  logic [N_PORTS*W_DATA-1:0]   dst_hrdata,
   output logic                        err_valid,
   output logic [W_ADDR-1:0]           err_addr,
   output logic                        err_write,
   input  logic                        err_clr
);

   localparam int W_SEL = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SLV,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t             state_q, state_d;
   logic [W_SEL-1:0]   sel_q, sel_d;
   logic [W_SEL-1:0]   win;
   logic               hit_any;
   logic               miss_acc;

   // Address decode: scan from the top so the lowest matching port wins.
   always_comb begin
      hit_any = 1'b0;
      win     = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR])
             == ADDR_MAP[i*W_ADDR +: W_ADDR]) begin
            hit_any = 1'b1;
            win     = W_SEL'(i);
         end
      end
   end

   // An active transfer to no port is accepted outside the ERR1 cycle.
   assign miss_acc = src_hready && (state_q != S_ERR1)
                     && src_htrans[1] && !hit_any;

   assign dst_hready    = {N_PORTS{src_hready}};
   assign dst_haddr     = {N_PORTS{src_haddr}};
   assign dst_hwrite    = {N_PORTS{src_hwrite}};
   assign dst_hsize     = {N_PORTS{src_hsize}};
   assign dst_hburst    = {N_PORTS{src_hburst}};
   assign dst_hprot     = {N_PORTS{src_hprot}};
   assign dst_hmastlock = {N_PORTS{src_hmastlock}};
   assign dst_hwdata    = {N_PORTS{src_hwdata}};

   // Only the winning port sees the real htrans; the rest see IDLE.
   always_comb begin
      dst_htrans = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (hit_any && (win == W_SEL'(i)))
            dst_htrans[i*2 +: 2] = src_htrans;
      end
   end

   // Data-phase next state; ERR1 always advances regardless of hready.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end else if (src_hready) begin
         if (src_htrans[1]) begin
            if (hit_any) begin
               state_d = S_SLV;
               sel_d   = win;
            end else begin
               state_d = S_ERR1;
            end
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // Response mux driven from registered state only.
   always_comb begin
      src_hready_resp = 1'b1;
      src_hresp       = 1'b0;
      src_hrdata      = '0;
      unique case (state_q)
         S_IDLE: begin
            src_hready_resp = 1'b1;
         end
         S_SLV: begin
            for (int i = 0; i < N_PORTS; i++) begin
               if (sel_q == W_SEL'(i)) begin
                  src_hready_resp = dst_hready_resp[i];
                  src_hresp       = dst_hresp[i];
                  src_hrdata      = dst_hrdata[i*W_DATA +: W_DATA];
               end
            end
         end
         S_ERR1: begin
            src_hready_resp = 1'b0;
            src_hresp       = 1'b1;
         end
         S_ERR2: begin
            src_hready_resp = 1'b1;
            src_hresp       = 1'b1;
         end
         default: begin
            src_hready_resp = 1'b1;
         end
      endcase
   end

   // State and selected-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

`ifdef AHBL_DECODER_ERRCAPTURE_EN
   logic              err_valid_q;
   logic [W_ADDR-1:0] err_addr_q;
   logic              err_write_q;

   // Sticky capture of the first unmapped access; a new miss beats clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_write_q <= 1'b0;
      end else begin
         if (err_clr)
            err_valid_q <= 1'b0;
         if (miss_acc && (!err_valid_q || err_clr)) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= src_haddr;
            err_write_q <= src_hwrite;
         end
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_write = err_write_q;
`else
   logic unused_err;

   assign unused_err = err_clr ^ miss_acc;
   assign err_valid  = 1'b0;
   assign err_addr   = '0;
   assign err_write  = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_decoder_n.sv
// Bench for ahbl_decoder_n: directed scenarios then random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_ahbl_decoder_n;

   localparam int NP = 4;
`ifdef AHBL_DECODER_ERRCAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic [31:0] MAP [4] = '{32'h40000000, 32'h42000000,
                            32'h48000000, 32'h49000000};

   logic clk = 0;
   always #5 clk = ~clk;

   logic        rst = 1;
   logic        hr_force = 0, hr_val = 1;
   logic [31:0] haddr = 0, hwdata = 0;
   logic        hwrite = 0, hmastlock = 0, err_clr = 0;
   logic [1:0]  htrans = 0;
   logic [2:0]  hsize = 3'd2, hburst = 0;
   logic [3:0]  hprot = 4'h3;
   logic        rrdy [4] = '{1, 1, 1, 1};
   logic        rresp [4] = '{0, 0, 0, 0};
   logic [31:0] rdata [4] = '{0, 0, 0, 0};

   logic         src_hready, src_hready_resp, src_hresp;
   logic [31:0]  src_hrdata;
   logic [3:0]   dst_hready, dst_hready_resp, dst_hresp;
   logic [127:0] dst_haddr, dst_hwdata, dst_hrdata;
   logic [3:0]   dst_hwrite, dst_hmastlock;
   logic [7:0]   dst_htrans;
   logic [11:0]  dst_hsize, dst_hburst;
   logic [15:0]  dst_hprot;
   logic         err_valid, err_write;
   logic [31:0]  err_addr;

   assign src_hready = hr_force ? hr_val : src_hready_resp;
   assign dst_hready_resp = {rrdy[3], rrdy[2], rrdy[1], rrdy[0]};
   assign dst_hresp = {rresp[3], rresp[2], rresp[1], rresp[0]};
   assign dst_hrdata = {rdata[3], rdata[2], rdata[1], rdata[0]};

   ahbl_decoder_n #(
      .N_PORTS  (4),
      .W_ADDR   (32),
      .W_DATA   (32),
      .ADDR_MAP ({32'h49000000, 32'h48000000,
                  32'h42000000, 32'h40000000}),
      .ADDR_MASK({4{32'hFF000000}})
   ) dut (
      .clk(clk), .rst(rst),
      .src_hready(src_hready),
      .src_hready_resp(src_hready_resp),
      .src_hresp(src_hresp),
      .src_haddr(haddr), .src_hwrite(hwrite),
      .src_htrans(htrans), .src_hsize(hsize),
      .src_hburst(hburst), .src_hprot(hprot),
      .src_hmastlock(hmastlock), .src_hwdata(hwdata),
      .src_hrdata(src_hrdata),
      .dst_hready(dst_hready),
      .dst_hready_resp(dst_hready_resp),
      .dst_hresp(dst_hresp),
      .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
      .dst_htrans(dst_htrans), .dst_hsize(dst_hsize),
      .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
      .dst_hmastlock(dst_hmastlock),
      .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
      .err_valid(err_valid), .err_addr(err_addr),
      .err_write(err_write), .err_clr(err_clr)
   );

   int checks = 0, passed = 0, fails = 0;

   // Model: what the current data phase belongs to.
   // -1 none, 0..3 slave port, 4 first error cycle, 5 second.
   int          owner = -1;
   logic        m_ev = 0, m_ew = 0;
   logic [31:0] m_ea = 0;

   function automatic int dec(logic [31:0] a);
      for (int i = 0; i < NP; i++)
         if ((a & 32'hFF000000) == MAP[i]) return i;
      return -1;
   endfunction

   task automatic chk(string tag, logic [127:0] obs,
                      logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // One bus cycle: check outputs mid-cycle, then advance the model.
   task automatic step();
      logic e_rdy, e_rsp, e_hr;
      logic [31:0] e_dat;
      logic [7:0] e_tr;
      int p;
      #2;
      e_rdy = 1; e_rsp = 0; e_dat = 0;
      if (owner >= 0 && owner < NP) begin
         e_rdy = rrdy[owner];
         e_rsp = rresp[owner];
         e_dat = rdata[owner];
      end else if (owner == 4) begin
         e_rdy = 0; e_rsp = 1;
      end else if (owner == 5) begin
         e_rdy = 1; e_rsp = 1;
      end
      e_hr = hr_force ? hr_val : e_rdy;
      p = dec(haddr);
      e_tr = (p >= 0) ? (8'(htrans) << (2 * p)) : 8'h0;
      chk("hready_resp", 128'(src_hready_resp), 128'(e_rdy));
      chk("hresp", 128'(src_hresp), 128'(e_rsp));
      chk("hrdata", 128'(src_hrdata), 128'(e_dat));
      chk("dst_htrans", 128'(dst_htrans), 128'(e_tr));
      chk("dst_hready", 128'(dst_hready), 128'({4{e_hr}}));
      chk("dst_haddr", dst_haddr, {4{haddr}});
      chk("dst_hwdata", dst_hwdata, {4{hwdata}});
      chk("err_valid", 128'(err_valid), 128'(CAP & m_ev));
      chk("err_addr", 128'(err_addr), 128'(CAP ? m_ea : 32'h0));
      chk("err_write", 128'(err_write), 128'(CAP & m_ew));
      @(posedge clk);
      if (rst) begin
         owner = -1; m_ev = 0; m_ea = 0; m_ew = 0;
      end else begin
         if (err_clr) m_ev = 0;
         if (owner != 4 && e_hr && htrans[1] && p < 0
             && (!m_ev || err_clr || owner == 4)) begin
            m_ev = 1; m_ea = haddr; m_ew = hwrite;
         end
         if (owner == 4) owner = 5;
         else if (e_hr) owner = htrans[1] ? ((p >= 0) ? p : 4) : -1;
      end
      @(negedge clk);
   endtask

   task automatic addr(logic [31:0] a, logic [1:0] t, logic w);
      haddr = a; htrans = t; hwrite = w; hwdata = $urandom;
   endtask

   initial begin
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      step();
      rst = 0;
      step();

      addr(32'h48000010, 2'b10, 0);
      step();
      addr(32'h0, 2'b00, 0);
      rrdy[2] = 0;
      step();
      step();
      rrdy[2] = 1; rdata[2] = 32'hCAFEF00D;
      #1 chk("p2_rdata", 128'(src_hrdata), 128'(32'hCAFEF00D));
      step();

      addr(32'h50000000, 2'b10, 1);
      step();
      addr(32'h0, 2'b00, 0);
      step();
      step();
      step();

      addr(32'h60000000, 2'b10, 0);
      step();
      addr(32'h0, 2'b00, 0);
      step();
      step();
      addr(32'h70000000, 2'b10, 0);
      err_clr = 1;
      step();
      err_clr = 0;
      addr(32'h0, 2'b00, 0);
      step();
      step();
      step();

      err_clr = 1;
      step();
      err_clr = 0;
      addr(32'h50000000, 2'b00, 1);
      step();
      addr(32'h50000000, 2'b01, 1);
      step();
      addr(32'h0, 2'b00, 0);
      step();

      addr(32'h40000004, 2'b10, 1);
      step();
      rdata[3] = 32'h12345678;
      addr(32'h49000008, 2'b10, 0);
      step();
      addr(32'h55000000, 2'b10, 0);
      step();
      addr(32'h0, 2'b00, 0);
      step();
      step();

      addr(32'h42000020, 2'b10, 0);
      step();
      addr(32'h0, 2'b00, 0);
      rrdy[1] = 0;
      step();
      rst = 1;
      step();
      rst = 0;
      step();
      rrdy[1] = 1;

      for (int n = 0; n < 600; n++) begin
         int k;
         logic [31:0] a;
         k = $urandom_range(0, 5);
         a = (k < 4) ? (MAP[k] | ($urandom & 32'h00FFFFFC))
                     : ($urandom | 32'h80000000);
         addr(a, 2'($urandom), 1'($urandom));
         for (int i = 0; i < NP; i++) begin
            rrdy[i] = ($urandom_range(0, 3) != 0);
            rresp[i] = ($urandom_range(0, 7) == 0);
            rdata[i] = $urandom;
         end
         err_clr = ($urandom_range(0, 7) == 0);
         hr_force = ($urandom_range(0, 9) == 0);
         hr_val = 1'($urandom);
         rst = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
